// File: rtl/operand_deflattener_if.sv
// Half-vector input and full-vector output handshake bundle for operand_deflattener.
// The slave modport is the deflattener's view; master is the producer/consumer side.
interface operand_deflattener_if #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 32
);
    logic                         s_valid;
    logic                         s_ready;
    logic                         s_odd;
    logic [LANES*ELEM_W-1:0]      s_data;
    logic                         m_valid;
    logic                         m_ready;
    logic [2*LANES*ELEM_W-1:0]    m_data;

    modport slave (
        input  s_valid, s_odd, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_odd, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/operand_deflattener.sv
// Reassembles an even half-vector beat and an odd half-vector beat into one interleaved
// full vector (element 2i from the even beat, 2i+1 from the odd beat).
// Optional feature: define OPERAND_DEFLAT_OVERLAP_EN to accept the next even beat while
// a finished vector is still being held downstream.
module operand_deflattener #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    operand_deflattener_if.slave       bus,
    input  logic                       clear_err,
    output logic                       seq_err,
    output logic [15:0]                vec_count
);
    localparam int unsigned HALF_W = LANES * ELEM_W;
    localparam int unsigned VEC_W  = 2 * HALF_W;

    typedef enum logic [1:0] {StWaitEven, StWaitOdd, StHold} state_e;

    state_e              r_state;
    logic [HALF_W-1:0]   r_even;
    logic [VEC_W-1:0]    r_out;
    logic                r_m_valid;
    logic                r_seq_err;
    logic [15:0]         r_vec_count;

    logic                w_even_vld;
    logic                w_s_ready;
    logic                w_s_acc;
    logic                w_m_acc;
    logic                w_set_err;
    logic                w_even_next;
    logic [VEC_W-1:0]    w_interleave;

`ifdef OPERAND_DEFLAT_OVERLAP_EN
    logic r_even_vld;
    assign w_even_vld = r_even_vld;
`else
    assign w_even_vld = 1'b0;
`endif

    // Input ready depends only on state and the pending-even flag.
    always_comb begin
        w_s_ready = 1'b0;
        case (r_state)
            StWaitEven: w_s_ready = 1'b1;
            StWaitOdd:  w_s_ready = 1'b1;
`ifdef OPERAND_DEFLAT_OVERLAP_EN
            StHold:     w_s_ready = !w_even_vld;
`else
            StHold:     w_s_ready = 1'b0;
`endif
            default:    w_s_ready = 1'b0;
        endcase
    end

    assign w_s_acc = bus.s_valid && w_s_ready;
    assign w_m_acc = r_m_valid && bus.m_ready;

    // Any beat whose pass tag does not match what the state expects is an ordering error.
    assign w_set_err = w_s_acc && (((r_state == StWaitEven) && bus.s_odd) ||
                                   ((r_state == StWaitOdd) && !bus.s_odd) ||
                                   ((r_state == StHold) && bus.s_odd));

    // An even beat already captured (or arriving now) sends HOLD straight to WAIT_ODD.
    assign w_even_next = w_even_vld || (w_s_acc && !bus.s_odd && (r_state == StHold));

    // Pure bit placement of stored even lanes and incoming odd lanes.
    always_comb begin
        w_interleave = '0;
        for (int i = 0; i < LANES; i++) begin
            w_interleave[(2*i)*ELEM_W +: ELEM_W]   = r_even[i*ELEM_W +: ELEM_W];
            w_interleave[(2*i+1)*ELEM_W +: ELEM_W] = bus.s_data[i*ELEM_W +: ELEM_W];
        end
    end

    // Pass-ordering FSM with registered output vector, error flag and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StWaitEven;
            r_even      <= '0;
            r_out       <= '0;
            r_m_valid   <= 1'b0;
            r_seq_err   <= 1'b0;
            r_vec_count <= '0;
`ifdef OPERAND_DEFLAT_OVERLAP_EN
            r_even_vld  <= 1'b0;
`endif
        end else begin
            // Set has priority over clear.
            if (w_set_err) begin
                r_seq_err <= 1'b1;
            end else if (clear_err) begin
                r_seq_err <= 1'b0;
            end

            case (r_state)
                StWaitEven: begin
                    if (w_s_acc && !bus.s_odd) begin
                        r_even  <= bus.s_data;
                        r_state <= StWaitOdd;
                    end
                end
                StWaitOdd: begin
                    if (w_s_acc) begin
                        if (bus.s_odd) begin
                            r_out     <= w_interleave;
                            r_m_valid <= 1'b1;
                            r_state   <= StHold;
                        end else begin
                            r_even <= bus.s_data;
                        end
                    end
                end
                StHold: begin
`ifdef OPERAND_DEFLAT_OVERLAP_EN
                    if (w_s_acc && !bus.s_odd) begin
                        r_even     <= bus.s_data;
                        r_even_vld <= 1'b1;
                    end
`endif
                    if (w_m_acc) begin
                        r_m_valid   <= 1'b0;
                        r_vec_count <= r_vec_count + 16'd1;
                        if (w_even_next) begin
                            r_state <= StWaitOdd;
`ifdef OPERAND_DEFLAT_OVERLAP_EN
                            r_even_vld <= 1'b0;
`endif
                        end else begin
                            r_state <= StWaitEven;
                        end
                    end
                end
                default: r_state <= StWaitEven;
            endcase
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_out;
    assign seq_err     = r_seq_err;
    assign vec_count   = r_vec_count;

endmodule

// File: tb/tb_operand_deflattener.sv
// Scoreboard bench for operand_deflattener: expected vectors are queued when the odd beat
// is driven and popped when the DUT presents its output.
module tb_operand_deflattener;
    localparam int unsigned LANES  = 16;
    localparam int unsigned ELEM_W = 32;
    localparam int unsigned HALF_W = LANES * ELEM_W;
    localparam int unsigned VEC_W  = 2 * HALF_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_err = 1'b0;
    logic        seq_err;
    logic [15:0] vec_count;

    int errors = 0;
    int checks = 0;
    logic [VEC_W-1:0] exp_q[$];
    logic [15:0]      exp_count = 16'd0;

    operand_deflattener_if #(.LANES(LANES), .ELEM_W(ELEM_W)) bus ();

    operand_deflattener #(.LANES(LANES), .ELEM_W(ELEM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clear_err (clear_err),
        .seq_err   (seq_err),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] interleave(input logic [HALF_W-1:0] ev,
                                                    input logic [HALF_W-1:0] od);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < 2*LANES; k++) begin
            if (k % 2 == 0) v[k*ELEM_W +: ELEM_W] = ev[(k/2)*ELEM_W +: ELEM_W];
            else            v[k*ELEM_W +: ELEM_W] = od[(k/2)*ELEM_W +: ELEM_W];
        end
        return v;
    endfunction

    function automatic logic [HALF_W-1:0] rand_half();
        logic [HALF_W-1:0] h;
        for (int i = 0; i < LANES; i++) h[i*ELEM_W +: ELEM_W] = $urandom;
        return h;
    endfunction

    function automatic logic [HALF_W-1:0] ramp_half(input int off);
        logic [HALF_W-1:0] h;
        for (int i = 0; i < LANES; i++) h[i*ELEM_W +: ELEM_W] = 32'h100 + 2*i + off;
        return h;
    endfunction

    // Drives one beat and returns #1 after the accepting edge.
    task automatic send_beat(input logic odd, input logic [HALF_W-1:0] data);
        int cyc = 0;
        bus.s_valid = 1'b1;
        bus.s_odd   = odd;
        bus.s_data  = data;
        while (!bus.s_ready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.s_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: s_ready=%0b required 1", bus.s_ready);
        end
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.s_ready !== 1'b1) begin errors++;
            $display("FAIL rst_s_ready: got %0b want 1", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL rst_m_valid: got %0b want 0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin errors++;
            $display("FAIL rst_m_data: got %h want 0", bus.m_data); end
        checks++; if (seq_err !== 1'b0) begin errors++;
            $display("FAIL rst_seq_err: got %0b want 0", seq_err); end
        checks++; if (vec_count !== 16'd0) begin errors++;
            $display("FAIL rst_vec_count: got %h want 0", vec_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 16'd0;
    endtask

    task automatic test_basic();
        logic [HALF_W-1:0] ev, od;
        logic [VEC_W-1:0]  exp_v;
        logic              ramp_ok;
        ev = ramp_half(0);
        od = ramp_half(1);
        exp_q.push_back(interleave(ev, od));
        send_beat(1'b0, ev);
        checks++; if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL basic_early_valid: got %0b want 0", bus.m_valid); end
        send_beat(1'b1, od);
        checks++; if (bus.m_valid !== 1'b1) begin errors++;
            $display("FAIL basic_latency: m_valid=%0b want 1", bus.m_valid); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_data !== exp_v) begin errors++;
            $display("FAIL basic_data: got %h want %h", bus.m_data, exp_v); end
        ramp_ok = 1'b1;
        for (int k = 0; k < 2*LANES; k++)
            if (bus.m_data[k*ELEM_W +: ELEM_W] !== 32'h100 + k) ramp_ok = 1'b0;
        checks++; if (!ramp_ok) begin errors++;
            $display("FAIL basic_ramp: element k != 0x100+k, got %h", bus.m_data); end
        @(posedge clk); #1;
        exp_count++;
        checks++; if (vec_count !== exp_count) begin errors++;
            $display("FAIL basic_count: got %0d want %0d", vec_count, exp_count); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL basic_valid_drop: got %0b want 0", bus.m_valid); end
    endtask

    task automatic test_backpressure();
        logic [HALF_W-1:0] ev, od, ev2, od2;
        logic [VEC_W-1:0]  held, exp_v;
        int                acc;
        logic              stable;
        int                exp_acc;
`ifdef OPERAND_DEFLAT_OVERLAP_EN
        exp_acc = 1;
`else
        exp_acc = 0;
`endif
        bus.m_ready = 1'b0;
        ev = rand_half(); od = rand_half(); ev2 = rand_half(); od2 = rand_half();
        exp_q.push_back(interleave(ev, od));
        send_beat(1'b0, ev);
        send_beat(1'b1, od);
        checks++; if (bus.m_valid !== 1'b1) begin errors++;
            $display("FAIL bp_valid: got %0b want 1", bus.m_valid); end
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_data !== exp_v) begin errors++;
            $display("FAIL bp_data: got %h want %h", bus.m_data, exp_v); end
        held = exp_v;
        bus.s_valid = 1'b1; bus.s_odd = 1'b0; bus.s_data = ev2;
        acc = 0; stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b1 || bus.m_data !== held) stable = 1'b0;
            if (bus.s_ready && i < 9) acc++;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        checks++; if (!stable) begin errors++;
            $display("FAIL bp_stable: m_data/m_valid changed, now %h want %h", bus.m_data, held); end
        checks++; if (acc != exp_acc) begin errors++;
            $display("FAIL bp_accepts: got %0d want %0d", acc, exp_acc); end
        @(posedge clk); #1;
        exp_count++;
        checks++; if (vec_count !== exp_count) begin errors++;
            $display("FAIL bp_count: got %0d want %0d", vec_count, exp_count); end
`ifdef OPERAND_DEFLAT_OVERLAP_EN
        exp_q.push_back(interleave(ev2, od2));
        send_beat(1'b1, od2);
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_v) begin errors++;
            $display("FAIL bp_overlap_data: got %h want %h", bus.m_data, exp_v); end
        @(posedge clk); #1;
        exp_count++;
`endif
    endtask

    task automatic test_ordering();
        logic [HALF_W-1:0] x, a, b, c;
        logic [VEC_W-1:0]  exp_v;
        x = rand_half(); a = rand_half(); b = rand_half(); c = rand_half();
        send_beat(1'b1, x);
        checks++; if (seq_err !== 1'b1) begin errors++;
            $display("FAIL ord_err_set: got %0b want 1", seq_err); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++;
            $display("FAIL ord_dropped: m_valid=%0b want 0", bus.m_valid); end
        send_beat(1'b0, a);
        send_beat(1'b0, b);
        exp_q.push_back(interleave(b, c));
        send_beat(1'b1, c);
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_v) begin errors++;
            $display("FAIL ord_data: got %h want %h", bus.m_data, exp_v); end
        @(posedge clk); #1;
        exp_count++;
        checks++; if (vec_count !== exp_count) begin errors++;
            $display("FAIL ord_count: got %0d want %0d", vec_count, exp_count); end
        // Clear while a fresh violation lands in the same cycle: set wins.
        bus.s_valid = 1'b1; bus.s_odd = 1'b1; bus.s_data = x; clear_err = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0; clear_err = 1'b0;
        checks++; if (seq_err !== 1'b1) begin errors++;
            $display("FAIL ord_set_wins: got %0b want 1", seq_err); end
        clear_err = 1'b1;
        @(posedge clk); #1;
        clear_err = 1'b0;
        checks++; if (seq_err !== 1'b0) begin errors++;
            $display("FAIL ord_clear: got %0b want 0", seq_err); end
    endtask

    task automatic test_overlap_throughput();
        int n = 0;
        int bound;
        logic [VEC_W-1:0] exp_v;
`ifdef OPERAND_DEFLAT_OVERLAP_EN
        bound = 17;
`else
        bound = 25;
`endif
        fork
            begin
                for (int p = 0; p < 8; p++) begin
                    logic [HALF_W-1:0] ev, od;
                    ev = rand_half(); od = rand_half();
                    send_beat(1'b0, ev);
                    exp_q.push_back(interleave(ev, od));
                    send_beat(1'b1, od);
                end
            end
            begin
                for (int c = 0; c < bound && n < 8; c++) begin
                    @(negedge clk);
                    if (bus.m_valid) begin
                        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                        checks++;
                        if (bus.m_data !== exp_v) begin errors++;
                            $display("FAIL tput_data[%0d]: got %h want %h", n, bus.m_data, exp_v);
                        end
                        n++;
                    end
                end
            end
        join
        checks++; if (n != 8) begin errors++;
            $display("FAIL tput_outputs: got %0d in %0d cycles want 8", n, bound); end
        @(posedge clk); #1;
        exp_count += 16'(n);
        checks++; if (vec_count !== exp_count) begin errors++;
            $display("FAIL tput_count: got %0d want %0d", vec_count, exp_count); end
        exp_q.delete();
    endtask

    task automatic test_reset_midop();
        logic [HALF_W-1:0] a, b, c;
        logic [VEC_W-1:0]  exp_v;
        a = rand_half(); b = rand_half(); c = rand_half();
        send_beat(1'b0, a);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++;
            $display("FAIL midrst_outputs: m_valid=%0b s_ready=%0b want 0/1",
                     bus.m_valid, bus.s_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_count = 16'd0;
        exp_q.delete();
        exp_q.push_back(interleave(b, c));
        send_beat(1'b0, b);
        send_beat(1'b1, c);
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== exp_v) begin errors++;
            $display("FAIL midrst_data: got %h want %h", bus.m_data, exp_v); end
        @(posedge clk); #1;
        exp_count++;
        checks++; if (vec_count !== exp_count) begin errors++;
            $display("FAIL midrst_count: got %0d want %0d", vec_count, exp_count); end
        checks++; if (seq_err !== 1'b0) begin errors++;
            $display("FAIL midrst_seq_err: got %0b want 0", seq_err); end
    endtask

    task automatic test_counter_wrap();
        logic [HALF_W-1:0] ev, od;
        logic [VEC_W-1:0]  exp_v;
        force dut.r_vec_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_vec_count;
        checks++; if (vec_count !== 16'hFFFF) begin errors++;
            $display("FAIL wrap_preset: got %h want ffff", vec_count); end
        ev = rand_half(); od = rand_half();
        exp_q.push_back(interleave(ev, od));
        send_beat(1'b0, ev);
        send_beat(1'b1, od);
        exp_v = exp_q.pop_front();
        checks++; if (bus.m_data !== exp_v) begin errors++;
            $display("FAIL wrap_data: got %h want %h", bus.m_data, exp_v); end
        @(posedge clk); #1;
        checks++; if (vec_count !== 16'h0000) begin errors++;
            $display("FAIL wrap_count: got %h want 0000", vec_count); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_odd   = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_ordering();
        test_overlap_throughput();
        test_reset_midop();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/operand_deflattener.md
# operand_deflattener

Receiving end of the two-pass operand flattening protocol. It accepts the even half-vector beat (elements 0, 2, …, 30) followed by the odd half-vector beat (elements 1, 3, …, 31) from the multiplier-array result path. It re-interleaves the two beats into one full 32-element vector and presents that vector downstream on a valid/ready interface. It sits between the operand transformer's temporal result registers and the writeback/collector stage.

## Interface
Parameters:
- LANES, 16, elements per half-vector beat
- ELEM_W, 32, bits per element

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_odd  in  1  pass tag: 0 = even beat, 1 = odd beat
- s_data  in  LANES*ELEM_W  half-vector; lane i at bits [i*ELEM_W +: ELEM_W]
- m_valid  out  1  reassembled vector valid
- m_ready  in  1  downstream accept
- m_data  out  2*LANES*ELEM_W  full vector; element k at bits [k*ELEM_W +: ELEM_W]
- seq_err  out  1  sticky pass-ordering error
- clear_err  in  1  synchronous clear of seq_err
- vec_count  out  16  count of output handshakes, wraps 0xFFFF→0

## Operation
- Storage: even_q (LANES*ELEM_W), out_q (2*LANES*ELEM_W, drives m_data), even_vld flag.
- States: WAIT_EVEN, WAIT_ODD, HOLD. Reset state is WAIT_EVEN.
- WAIT_EVEN: s_ready=1.
  - Accepted beat with s_odd=0: even_q ← s_data, go to WAIT_ODD.
  - Accepted beat with s_odd=1: beat is dropped, seq_err ← 1, stay.
- WAIT_ODD: s_ready=1.
  - Accepted beat with s_odd=1: out_q[2i] ← even_q[i], out_q[2i+1] ← s_data[i] for i in 0..LANES-1. Go to HOLD.
  - Accepted beat with s_odd=0: even_q is overwritten, seq_err ← 1, stay.
- HOLD: m_valid=1.
  - On m_ready: vec_count increments. Next state is WAIT_ODD if even_vld (then even_vld ← 0), else WAIT_EVEN.
  - Without m_ready: stay, and out_q is held stable.
- seq_err:
  - Set by either ordering violation.
  - Cleared by clear_err.
  - If set and clear occur in the same cycle, set wins.
- Interleave is pure bit placement. No arithmetic is performed and no width change occurs per element.

## Timing
- Reset values: state=WAIT_EVEN, m_valid=0, m_data=0, seq_err=0, vec_count=0, even_vld=0.
- s_ready is combinational from state and even_vld only; it never depends on s_valid or s_odd. s_ready=1 while in reset.
- m_valid and m_data are registered.
- Latency: odd beat accepted in cycle N gives m_valid=1 in cycle N+1.
- Once m_valid is high, m_valid and m_data stay constant until m_ready is sampled high.
- Reset mid-operation: any partial even beat and any held vector are discarded immediately. No output is produced for them.
- Throughput without the overlap feature: one vector per 3 cycles minimum.

## Configuration
- OPERAND_DEFLAT_OVERLAP_EN, defined:
  - In HOLD, s_ready = !even_vld.
  - An accepted s_odd=0 beat loads even_q and sets even_vld.
  - An accepted s_odd=1 beat is dropped and sets seq_err.
  - If m_ready fires in the same cycle as an even-beat accept, the FSM goes to WAIT_ODD.
  - Sustained throughput: one vector per 2 cycles.
- OPERAND_DEFLAT_OVERLAP_EN, undefined:
  - In HOLD, s_ready=0.
  - even_vld is tied 0.

## Test plan
- Basic reassembly:
  - Stimulus: even beat with lane i = 0x100+2i, then odd beat with lane i = 0x100+2i+1, m_ready=1.
  - Response: m_data element k = 0x100+k for k=0..31; m_valid high one cycle after the odd accept; vec_count=1.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles after m_valid.
  - Response: m_data is unchanged throughout. Without the macro, s_ready=0 for all 10 cycles; with it, exactly one even beat is accepted. After m_ready is released, vec_count increments by 1.
- Ordering errors:
  - Stimulus: odd beat in WAIT_EVEN, then even A, even B, odd C.
  - Response: seq_err=1 after the first beat. The output is interleave(B, C). clear_err then drops seq_err to 0 next cycle.
- Overlap throughput (macro defined):
  - Stimulus: 8 back-to-back even/odd pairs with m_ready=1.
  - Response: 8 outputs within 17 cycles of the first accept, each correct; vec_count=8.
- Reset mid-operation:
  - Stimulus: rst_n asserted after the even beat, then a new pair sent.
  - Response: only the new pair's vector is output; vec_count=1; seq_err=0.
- Counter wrap:
  - Stimulus: force vec_count to 0xFFFF, then complete one vector.
  - Response: vec_count=0x0000.
